up_datapath: RTL

UP_DATAPATH -- requirements
Module: up_datapath

---
 rtl/up_pkg.sv | 24 ++
 rtl/up_datapath_if.sv | 41 ++++
 rtl/up_ram32x8.sv | 29 ++
 rtl/up_datapath.sv | 98 +++++++++
 4 files changed

// File: rtl/up_pkg.sv
// Shared constants for the accumulator datapath: opcodes, accumulator source
// selects and default widths.
package up_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_INPUT = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  localparam logic [1:0] ASEL_ALU   = 2'b00;
  localparam logic [1:0] ASEL_INPUT = 2'b01;
  localparam logic [1:0] ASEL_MEM   = 2'b10;
  localparam logic [1:0] ASEL_ZERO  = 2'b11;

endpackage

// File: rtl/up_datapath_if.sv
// Control-unit <-> datapath bundle. The Ovf status line exists only when
// UP_DATAPATH_OVF_EN is defined.
interface up_datapath_if
  import up_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0]        Asel;
  logic [DATA_W-1:0] Input;
  logic              ProgWr;
  logic [ADDR_W-1:0] ProgAddr;
  logic [DATA_W-1:0] ProgData;
  logic [2:0]        IR;
  logic              Aeq0, Apos;
  logic [DATA_W-1:0] Output;
  logic [ADDR_W-1:0] PCout;
`ifdef UP_DATAPATH_OVF_EN
  logic              Ovf;
`endif

  modport master (
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel,
           Input, ProgWr, ProgAddr, ProgData,
`ifdef UP_DATAPATH_OVF_EN
    input  Ovf,
`endif
    input  IR, Aeq0, Apos, Output, PCout
  );

  modport slave (
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel,
           Input, ProgWr, ProgAddr, ProgData,
`ifdef UP_DATAPATH_OVF_EN
    output Ovf,
`endif
    output IR, Aeq0, Apos, Output, PCout
  );

endinterface

// File: rtl/up_ram32x8.sv
// Program/data memory: one write port where the program loader beats the
// datapath store, plus an asynchronous read port. Contents survive reset.
module up_ram32x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end else if (mem_we) begin
      mem_q[mem_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[mem_addr];

endmodule

// File: rtl/up_datapath.sv
// Accumulator datapath: IR, PC, A registers around a 32x8 memory.
// Optional sticky signed-overflow flag enabled by UP_DATAPATH_OVF_EN.
module up_datapath
  import up_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic          CLOCK,
  input  logic          RESET,
  up_datapath_if.slave  bus
);

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] alu_res;
  logic              mem_we;

  assign mem_addr = bus.Meminst ? ir_q[ADDR_W-1:0] : pc_q;
  assign alu_res  = bus.Sub ? (a_q - rd_data) : (a_q + rd_data);
  // Stores are suppressed while halted or in reset; the loader port is not.
  assign mem_we   = bus.MemWr && !bus.Halt && !RESET;

  up_ram32x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (CLOCK),
    .prog_we   (bus.ProgWr),
    .prog_addr (bus.ProgAddr),
    .prog_data (bus.ProgData),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .wr_data   (a_q),
    .rd_data   (rd_data)
  );

  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    a_d  = a_q;
    if (!bus.Halt) begin
      if (bus.IRload) ir_d = rd_data;
      if (bus.PCload) pc_d = bus.JMPmux ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      if (bus.Aload) begin
        unique case (bus.Asel)
          ASEL_ALU:   a_d = alu_res;
          ASEL_INPUT: a_d = bus.Input;
          ASEL_MEM:   a_d = rd_data;
          default:    a_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ir_q <= '0;
      pc_q <= '0;
      a_q  <= '0;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
      a_q  <= a_d;
    end
  end

`ifdef UP_DATAPATH_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_hit;

  // Add overflows on equal operand signs; subtract on differing signs.
  always_comb begin
    ovf_hit = 1'b0;
    if (bus.Sub) begin
      ovf_hit = (a_q[DATA_W-1] != rd_data[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
    end else begin
      ovf_hit = (a_q[DATA_W-1] == rd_data[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
    end
    ovf_d = ovf_q;
    if (!bus.Halt && bus.Aload && (bus.Asel == ASEL_ALU) && ovf_hit) ovf_d = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.Ovf = ovf_q;
`endif

  assign bus.IR     = ir_q[DATA_W-1 -: 3];
  assign bus.Output = a_q;
  assign bus.PCout  = pc_q;
  assign bus.Aeq0   = (a_q == '0);
  assign bus.Apos   = !a_q[DATA_W-1] && (a_q != '0);

endmodule
